// File: rtl/fft_accel_ctrl.sv
// Bus-mapped sequencer for the FFT core: buffers N input samples from the CPU,
// streams them into the core one per cycle and collects N results for readback.
module fft_accel_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int          N_POINTS  = 64,
    parameter int          IN_WIDTH  = 12,
    parameter int          OUT_WIDTH = 16,
    parameter int          TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_en_i,
    input  logic [3:0]           mem_we_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          mem_wdata_i,
    output logic [31:0]          mem_rdata_o,
    output logic                 irq_o,
    output logic                 fft_start_o,
    output logic                 fft_in_valid_o,
    output logic [IN_WIDTH-1:0]  fft_din_r_o,
    output logic [IN_WIDTH-1:0]  fft_din_i_o,
    input  logic                 fft_out_valid_i,
    input  logic [OUT_WIDTH-1:0] fft_dout_r_i,
    input  logic [OUT_WIDTH-1:0] fft_dout_i_i
);

    localparam int AW = $clog2(N_POINTS);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] N_CNT     = CW'(N_POINTS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N_POINTS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [2*IN_WIDTH-1:0]  in_buf  [N_POINTS];
    logic [2*OUT_WIDTH-1:0] out_buf [N_POINTS];

    logic [CW-1:0] in_cnt, out_cnt, rd_ptr;
    logic [AW-1:0] feed_idx;
    logic [TW-1:0] wait_cnt;
    logic          ie, timeout_flag, ovf;
    logic          timeout_set;
    logic [31:0]   rdata_d;

    // Bus decode
    logic       hit, wr_en, rd_en;
    logic [1:0] off;
    logic       busy, done, full, feeding;
    logic       ctrl_wr, din_wr, dout_rd, dout_avail;
    logic       do_clear, do_start, capture;

    assign hit     = mem_en_i && (mem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = hit && (mem_we_i != 4'b0000);
    assign rd_en   = hit && (mem_we_i == 4'b0000);
    assign off     = mem_addr_i[3:2];

    assign feeding = (state == S_FEED);
    assign busy    = feeding || (state == S_WAIT);
    assign done    = (state == S_DONE);
    assign full    = (in_cnt == N_CNT);

    assign ctrl_wr    = wr_en && (off == 2'd0);
    assign din_wr     = wr_en && (off == 2'd2) && !busy;
    assign dout_rd    = rd_en && (off == 2'd3);
    assign dout_avail = (rd_ptr != out_cnt);

    // Clear takes priority over start when both bits arrive in one write.
    assign do_clear = ctrl_wr && !busy && mem_wdata_i[1];
    assign do_start = ctrl_wr && !busy && mem_wdata_i[0] && !mem_wdata_i[1]
                      && (state == S_IDLE) && full;
    assign capture  = fft_out_valid_i && busy && (out_cnt != N_CNT);

    logic signed [OUT_WIDTH-1:0] dout_r, dout_i;
    assign dout_r = out_buf[rd_ptr[AW-1:0]][OUT_WIDTH-1:0];
    assign dout_i = out_buf[rd_ptr[AW-1:0]][2*OUT_WIDTH-1:OUT_WIDTH];

    logic unused_bits;
    assign unused_bits = ^{mem_addr_i[1:0], mem_wdata_i[31:16+IN_WIDTH],
                           mem_wdata_i[15:IN_WIDTH]};

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d     = state;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: if (do_start) state_d = S_FEED;
            S_FEED: if (feed_idx == LAST_IDX) state_d = S_WAIT;
            S_WAIT: begin
                if (out_cnt == N_CNT) begin
                    state_d = S_DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_d     = S_DONE;
                    timeout_set = 1'b1;
                end
            end
            S_DONE: if (do_clear) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (off)
                2'd0:    rdata_d = {29'b0, ie, 2'b0};
                2'd1:    rdata_d = {16'(in_cnt), 12'b0, ovf, timeout_flag, done, busy};
                2'd3:    if (dout_avail) rdata_d = {16'(dout_i), 16'(dout_r)};
                default: rdata_d = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            in_cnt       <= '0;
            out_cnt      <= '0;
            rd_ptr       <= '0;
            feed_idx     <= '0;
            wait_cnt     <= '0;
            ie           <= 1'b0;
            timeout_flag <= 1'b0;
            ovf          <= 1'b0;
            mem_rdata_o  <= '0;
        end else begin
            state       <= state_d;
            mem_rdata_o <= rdata_d;
            feed_idx    <= feeding ? feed_idx + 1'b1 : '0;
            wait_cnt    <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;

            if (ctrl_wr) ie <= mem_wdata_i[2];

            if (do_clear) begin
                in_cnt       <= '0;
                out_cnt      <= '0;
                rd_ptr       <= '0;
                timeout_flag <= 1'b0;
                ovf          <= 1'b0;
            end else begin
                if (din_wr && !full) in_cnt <= in_cnt + 1'b1;
                if (din_wr && full)  ovf <= 1'b1;
                if (capture)         out_cnt <= out_cnt + 1'b1;
                if (dout_rd && dout_avail) rd_ptr <= rd_ptr + 1'b1;
                if (timeout_set)     timeout_flag <= 1'b1;
            end
        end
    end

    // NOTE: sample buffers carry no reset; validity is tracked by the counters, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (din_wr && !full)
            in_buf[in_cnt[AW-1:0]] <= {mem_wdata_i[16+IN_WIDTH-1:16], mem_wdata_i[IN_WIDTH-1:0]};
        if (capture)
            out_buf[out_cnt[AW-1:0]] <= {fft_dout_i_i, fft_dout_r_i};
    end

    assign fft_in_valid_o = feeding;
    assign fft_start_o    = feeding && (feed_idx == '0);
    assign fft_din_r_o    = feeding ? in_buf[feed_idx][IN_WIDTH-1:0] : '0;
    assign fft_din_i_o    = feeding ? in_buf[feed_idx][2*IN_WIDTH-1:IN_WIDTH] : '0;
    assign irq_o          = done && ie;

endmodule
